// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache between the memory controller
// instruction port and the instruction ROM. Hits complete after one busy
// cycle; misses refill a whole line word by word over the ROM enable/busy
// handshake and then complete as a hit.
// Optional feature: define INST_CACHE_FLUSH_EN to add a `flush` input that
// invalidates every line (FENCE.I support).
module inst_cache #(
  parameter int ADDR_SIZE  = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef INST_CACHE_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 inst_cache_enable,
  input  logic [ADDR_SIZE-1:0] inst_cache_addr,
  output logic [31:0]          inst_cache_data,
  output logic                 inst_cache_busy,
  output logic                 rom_enable,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [31:0]          rom_data,
  input  logic                 rom_busy
);

  localparam int WORD_BITS   = $clog2(LINE_WORDS);
  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int INDEX_BITS  = $clog2(LINES);
  localparam int TAG_BITS    = ADDR_SIZE - OFFSET_BITS - INDEX_BITS;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]            state;
  logic [TAG_BITS-1:0]   tag_q;
  logic [INDEX_BITS-1:0] index_q;
  logic [WORD_BITS-1:0]  word_q;
  logic [WORD_BITS-1:0]  counter;
  logic                  seen_busy;
  logic [LINES-1:0]      valid;
  logic                  hit;
`ifdef INST_CACHE_FLUSH_EN
  logic                  flush_pending;
`endif

  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES*LINE_WORDS];

  // The byte-within-word bits never select anything in a word-wide cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^inst_cache_addr[1:0];

  assign hit             = valid[index_q] && (tag_mem[index_q] == tag_q);
  assign inst_cache_busy = (state != S_IDLE) && (state != S_DONE);
  assign rom_enable      = (state == S_REQ) || (state == S_WAIT);
  assign rom_addr        = {tag_q, index_q, counter, 2'b00};

  // Control FSM: request latch, lookup, line refill sequencing and valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      tag_q           <= '0;
      index_q         <= '0;
      word_q          <= '0;
      counter         <= '0;
      seen_busy       <= 1'b0;
      inst_cache_data <= '0;
      valid           <= '0;
`ifdef INST_CACHE_FLUSH_EN
      flush_pending   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (inst_cache_enable) begin
            tag_q   <= inst_cache_addr[ADDR_SIZE-1 -: TAG_BITS];
            index_q <= inst_cache_addr[OFFSET_BITS +: INDEX_BITS];
            word_q  <= inst_cache_addr[2 +: WORD_BITS];
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            inst_cache_data <= data_mem[{index_q, word_q}];
            state           <= S_DONE;
          end else begin
            counter <= '0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          seen_busy <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (rom_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (counter == LAST_WORD) begin
            valid[index_q] <= 1'b1;
            state          <= S_LOOKUP;
          end else begin
            counter <= counter + WORD_BITS'(1);
            state   <= S_REQ;
          end
        end
        S_DONE: begin
          if (!inst_cache_enable) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef INST_CACHE_FLUSH_EN
      if (state == S_IDLE || state == S_DONE) begin
        if (flush) begin
          valid <= '0;
        end
      end else if (state == S_LOOKUP && hit) begin
        if (flush || flush_pending) begin
          valid <= '0;
        end
        flush_pending <= 1'b0;
      end else if (flush) begin
        flush_pending <= 1'b1;
      end
`endif
    end
  end

  // Line storage: ROM words land as they arrive, the tag when the line completes.
  always_ff @(posedge clock) begin
    if (state == S_WAIT && !rom_busy && seen_busy) begin
      data_mem[{index_q, counter}] <= rom_data;
    end
    if (state == S_GAP && counter == LAST_WORD) begin
      tag_mem[index_q] <= tag_q;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard testbench for inst_cache with a two-busy-cycle ROM model.
// Define INST_CACHE_FLUSH_EN to also exercise the flush port.
module tb_inst_cache;

  localparam int ROM_BUSY_CYCLES = 2;
  // Miss: LOOKUP + 4 x (REQ + 3 WAIT + GAP) + LOOKUP with this ROM model.
  localparam int MISS_BUSY = 22;
  localparam int HIT_BUSY  = 1;
  localparam int GUARD     = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
`ifdef INST_CACHE_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        inst_cache_enable = 1'b0;
  logic [31:0] inst_cache_addr = 32'h0;
  logic [31:0] inst_cache_data;
  logic        inst_cache_busy;
  logic        rom_enable;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic        rom_busy = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_data_q[$];
  logic [31:0] exp_rom_q[$];

  logic        mon_busy_prev = 1'b0;
  logic        mon_en_prev = 1'b0;

  int          rom_cnt = 0;
  logic        rom_active = 1'b0;
  logic        rom_done = 1'b0;
  logic [31:0] rom_lat_addr = 32'h0;

  inst_cache dut (
    .clock             (clock),
    .reset             (reset),
`ifdef INST_CACHE_FLUSH_EN
    .flush             (flush),
`endif
    .inst_cache_enable (inst_cache_enable),
    .inst_cache_addr   (inst_cache_addr),
    .inst_cache_data   (inst_cache_data),
    .inst_cache_busy   (inst_cache_busy),
    .rom_enable        (rom_enable),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .rom_busy          (rom_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // ROM model: accepts a request, stays busy for ROM_BUSY_CYCLES, then
  // presents data and waits for enable to drop before accepting another.
  always @(posedge clock) begin
    if (rom_active) begin
      if (rom_cnt == 0) begin
        rom_busy   <= 1'b0;
        rom_data   <= rom_word(rom_lat_addr);
        rom_active <= 1'b0;
        rom_done   <= 1'b1;
      end else begin
        rom_cnt <= rom_cnt - 1;
      end
    end else if (rom_done) begin
      if (!rom_enable) rom_done <= 1'b0;
    end else if (rom_enable) begin
      rom_active   <= 1'b1;
      rom_busy     <= 1'b1;
      rom_cnt      <= ROM_BUSY_CYCLES - 1;
      rom_lat_addr <= rom_addr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every completed fetch and every ROM request.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (!reset && mon_busy_prev && !inst_cache_busy) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done actual=0x%08h expected=none", inst_cache_data);
        end else begin
          checkOutput("fetch_data", inst_cache_data, exp_data_q.pop_front());
        end
      end
      if (rom_enable && !mon_en_prev) begin
        if (exp_rom_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rom_req actual=0x%08h expected=none", rom_addr);
        end else begin
          checkOutput("rom_addr", rom_addr, exp_rom_q.pop_front());
        end
      end
      mon_busy_prev = inst_cache_busy;
      mon_en_prev   = rom_enable;
    end
  end

  // One fetch: queue expectations, issue the request, scramble the address
  // after acceptance, measure busy length and ROM pulses, optionally hold enable.
  task automatic applyStimulus(input string name, input logic [31:0] addr,
                               input logic [31:0] exp_data, input int n_rom,
                               input logic [31:0] rom_base, input int exp_busy,
                               input int hold_cycles, input bit flush_in_lookup);
    int busy_cnt;
    int pulses;
    int guard;
    logic prev_en;
    exp_data_q.push_back(exp_data);
    for (int i = 0; i < n_rom; i++) exp_rom_q.push_back(rom_base + 32'(4 * i));
    @(negedge clock);
    inst_cache_enable = 1'b1;
    inst_cache_addr   = addr;
    @(negedge clock);
    inst_cache_addr = addr ^ 32'h0000_0F40;
`ifdef INST_CACHE_FLUSH_EN
    if (flush_in_lookup) flush = 1'b1;
`else
    if (flush_in_lookup) $display("[TB] flush request ignored in this build");
`endif
    busy_cnt = 0;
    pulses   = 0;
    guard    = 0;
    prev_en  = 1'b0;
    while (inst_cache_busy && guard < GUARD) begin
      busy_cnt++;
      if (rom_enable && !prev_en) pulses++;
      prev_en = rom_enable;
      @(negedge clock);
`ifdef INST_CACHE_FLUSH_EN
      flush = 1'b0;
`endif
      guard++;
    end
    checkOutput({name, "_no_timeout"}, 32'(guard < GUARD), 32'd1);
    checkOutput({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    checkOutput({name, "_rom_pulses"}, 32'(pulses), 32'(n_rom));
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clock);
      checkOutput({name, "_hold_busy"}, {31'b0, inst_cache_busy}, 32'd0);
      checkOutput({name, "_hold_rom_en"}, {31'b0, rom_enable}, 32'd0);
      checkOutput({name, "_hold_data"}, inst_cache_data, exp_data);
    end
    inst_cache_enable = 1'b0;
    @(negedge clock);
  endtask

  initial begin : main
    int guard;
    $display("[TB] inst_cache scoreboard bench start");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", {31'b0, inst_cache_busy}, 32'd0);
    checkOutput("reset_data", inst_cache_data, 32'd0);
    checkOutput("reset_rom_en", {31'b0, rom_enable}, 32'd0);
    checkOutput("reset_rom_addr", rom_addr, 32'd0);
    reset = 1'b0;

    // Cold miss, hits in the filled line, held enable
    applyStimulus("cold_miss_0x0", 32'h0000_0000, 32'hC0DE_0000, 4, 32'h0000_0000, MISS_BUSY, 0, 1'b0);
    applyStimulus("hit_0x8", 32'h0000_0008, 32'hC0DE_0008, 0, 32'h0, HIT_BUSY, 3, 1'b0);
    applyStimulus("hit_0xC", 32'h0000_000C, 32'hC0DE_000C, 0, 32'h0, HIT_BUSY, 0, 1'b0);

    // Index-0 conflict between 0x000 and 0x100
    applyStimulus("conflict_0x100", 32'h0000_0100, 32'hC0DE_0100, 4, 32'h0000_0100, MISS_BUSY, 0, 1'b0);
    applyStimulus("conflict_0x0", 32'h0000_0000, 32'hC0DE_0000, 4, 32'h0000_0000, MISS_BUSY, 0, 1'b0);
    applyStimulus("conflict_0x104", 32'h0000_0104, 32'hC0DE_0104, 4, 32'h0000_0100, MISS_BUSY, 0, 1'b0);

    // A different index fills without disturbing line 0
    applyStimulus("miss_0x14", 32'h0000_0014, 32'hC0DE_0014, 4, 32'h0000_0010, MISS_BUSY, 0, 1'b0);
    applyStimulus("hit_0x18", 32'h0000_0018, 32'hC0DE_0018, 0, 32'h0, HIT_BUSY, 0, 1'b0);
    applyStimulus("hit_0x108", 32'h0000_0108, 32'hC0DE_0108, 0, 32'h0, HIT_BUSY, 0, 1'b0);

    // Reset during the WAIT of refill word 1
    exp_rom_q.push_back(32'h0000_0000);
    exp_rom_q.push_back(32'h0000_0004);
    @(negedge clock);
    inst_cache_enable = 1'b1;
    inst_cache_addr   = 32'h0000_0000;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (!(rom_enable && rom_addr == 32'h0000_0004) && guard < GUARD);
    checkOutput("midfill_reach_word1", 32'(guard < GUARD), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midfill_reset_rom_en", {31'b0, rom_enable}, 32'd0);
    checkOutput("midfill_reset_busy", {31'b0, inst_cache_busy}, 32'd0);
    checkOutput("midfill_reset_rom_addr", rom_addr, 32'd0);
    checkOutput("midfill_reset_data", inst_cache_data, 32'd0);
    reset = 1'b0;
    inst_cache_enable = 1'b0;
    repeat (8) @(negedge clock);
    applyStimulus("refetch_0x0", 32'h0000_0000, 32'hC0DE_0000, 4, 32'h0000_0000, MISS_BUSY, 0, 1'b0);
    applyStimulus("post_reset_0x108", 32'h0000_0108, 32'hC0DE_0108, 4, 32'h0000_0100, MISS_BUSY, 0, 1'b0);

`ifdef INST_CACHE_FLUSH_EN
    // Flush during a hit's LOOKUP still returns data, then the line misses
    applyStimulus("flush_lookup_hit", 32'h0000_0104, 32'hC0DE_0104, 0, 32'h0, HIT_BUSY, 0, 1'b1);
    applyStimulus("after_flush_miss", 32'h0000_0104, 32'hC0DE_0104, 4, 32'h0000_0100, MISS_BUSY, 0, 1'b0);
    // Flush while idle
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    applyStimulus("idle_flush_miss", 32'h0000_010C, 32'hC0DE_010C, 4, 32'h0000_0100, MISS_BUSY, 0, 1'b0);
`endif

    repeat (4) @(negedge clock);
    checkOutput("leftover_data_expects", 32'(exp_data_q.size()), 32'd0);
    checkOutput("leftover_rom_expects", 32'(exp_rom_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
